// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM->WB stage: access sizes, writeback select, FSM states.
package mem_wb_stage_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;
    localparam logic [1:0] MEM_D = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load alignment: shifts read data down by the byte offset, truncates and extends.
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]                 rdata,
    input  logic [$clog2(XLEN/8)-1:0]       offset,
    input  logic [1:0]                      size,
    input  logic                            is_unsigned,
    output logic [XLEN-1:0]                 data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = shifted;
        case (size)
            MEM_B: begin
                if (is_unsigned) data = XLEN'(shifted[7:0]);
                else             data = XLEN'($signed(shifted[7:0]));
            end
            MEM_H: begin
                if (is_unsigned) data = XLEN'(shifted[15:0]);
                else             data = XLEN'($signed(shifted[15:0]));
            end
            default: begin
                // A dword request on a 32-bit datapath degrades to a word load.
                if (XLEN > 32 && size == MEM_D) data = shifted;
                else if (is_unsigned)           data = XLEN'(shifted[31:0]);
                else                            data = XLEN'($signed(shifted[31:0]));
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB stage with req/ack data-memory handshake and flush.
// Optional MEM_MISALIGN_TRAP_EN adds a misalign_trap output that blocks misaligned accesses.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int WB_SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic [XLEN-1:0]       alu_out,
    input  logic [XLEN-1:0]       store_data,
    input  logic [RA_W-1:0]       rd_addr,
    input  logic                  reg_write,
    input  logic [WB_SEL_W-1:0]   wb_mux,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    output logic [XLEN/8-1:0]     dmem_be,
    input  logic                  dmem_ack,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  out_valid,
    output logic [XLEN-1:0]       alu_out_wb,
    output logic [XLEN-1:0]       load_data_wb,
    output logic [RA_W-1:0]       rd_addr_out,
    output logic                  reg_write_out,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                  misalign_trap,
`endif
    output logic [WB_SEL_W-1:0]   wb_mux_out
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    function automatic logic [1:0] eff_size(input logic [1:0] s);
        return (XLEN == 32 && s == MEM_D) ? MEM_W : s;
    endfunction

    // Offset with the bits that fall inside the natural alignment of the access cleared.
    function automatic logic [OFF_W-1:0] align_off(input logic [1:0] s, input logic [OFF_W-1:0] o);
        case (s)
            MEM_B:   return o;
            MEM_H:   return o & ~OFF_W'(1);
            MEM_W:   return o & ~OFF_W'(3);
            default: return '0;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_en(input logic [1:0] s, input logic [OFF_W-1:0] o);
        case (s)
            MEM_B:   return BE_W'(1) << align_off(s, o);
            MEM_H:   return BE_W'(3) << align_off(s, o);
            MEM_W:   return BE_W'(15) << align_off(s, o);
            default: return '1;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_data(input logic [1:0] s, input logic [XLEN-1:0] d);
        case (s)
            MEM_B:   return {BE_W{d[7:0]}};
            MEM_H:   return {(BE_W/2){d[15:0]}};
            MEM_W:   return {(BE_W/4){d[31:0]}};
            default: return d;
        endcase
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] s, input logic [OFF_W-1:0] o);
        case (s)
            MEM_B:   return 1'b0;
            MEM_H:   return o[0];
            MEM_W:   return o[1:0] != 2'b00;
            default: return o != '0;
        endcase
    endfunction
`endif

    state_t          state, next_state;
    logic            flushed_p1;
    logic [1:0]      size_p1;
    logic            unsigned_p1;
    logic            reg_write_p1;
    logic            accept, is_mem, misaligned, start_mem, ack_done;
    logic [XLEN-1:0] aligned_load;

    assign is_mem = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = is_mem && is_misaligned(eff_size(mem_size), alu_out[OFF_W-1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign accept    = (state == ST_IDLE) && in_valid && !flush;
    assign start_mem = accept && is_mem && !misaligned;
    assign ack_done  = (state == ST_WAIT) && dmem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start_mem) next_state = ST_WAIT;
            ST_WAIT: if (dmem_ack)  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE);
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata       (dmem_rdata),
        .offset      (align_off(eff_size(size_p1), alu_out_wb[OFF_W-1:0])),
        .size        (size_p1),
        .is_unsigned (unsigned_p1),
        .data        (aligned_load)
    );

    // Stage boundary: execute -> bus request / writeback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            alu_out_wb   <= '0;
            load_data_wb <= '0;
            rd_addr_out  <= '0;
            reg_write_p1 <= 1'b0;
            wb_mux_out   <= '0;
            size_p1      <= '0;
            unsigned_p1  <= 1'b0;
            flushed_p1   <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_trap <= accept && misaligned;
`endif
            if (accept) begin
                alu_out_wb   <= alu_out;
                rd_addr_out  <= rd_addr;
                reg_write_p1 <= reg_write && !misaligned;
                wb_mux_out   <= wb_mux;
                size_p1      <= mem_size;
                unsigned_p1  <= mem_unsigned;
                if (start_mem) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= mem_write;
                    dmem_addr  <= alu_out & ~XLEN'(BE_W - 1);
                    dmem_wdata <= lane_data(eff_size(mem_size), store_data);
                    dmem_be    <= byte_en(eff_size(mem_size), alu_out[OFF_W-1:0]);
                    flushed_p1 <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                end
            end else if (ack_done) begin
                dmem_req     <= 1'b0;
                dmem_we      <= 1'b0;
                load_data_wb <= aligned_load;
                out_valid    <= !flushed_p1 && !flush;
                flushed_p1   <= 1'b0;
            end else if (state == ST_WAIT && flush) begin
                // The bus transaction still runs to completion; only its writeback is dropped.
                flushed_p1 <= 1'b1;
            end
        end
    end

    assign reg_write_out = reg_write_p1 & out_valid;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (XLEN=32): vector table plus hand-written handshake/flush/reset sequences.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush;
    logic [31:0] alu_out, store_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic [1:0]  wb_mux;
    logic        mem_read, mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [31:0] alu_out_wb, load_data_wb;
    logic [4:0]  rd_addr_out;
    logic        reg_write_out;
    logic [1:0]  wb_mux_out;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .RA_W(5), .WB_SEL_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .alu_out       (alu_out),
        .store_data    (store_data),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .wb_mux        (wb_mux),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_size      (mem_size),
        .mem_unsigned  (mem_unsigned),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .out_valid     (out_valid),
        .alu_out_wb    (alu_out_wb),
        .load_data_wb  (load_data_wb),
        .rd_addr_out   (rd_addr_out),
        .reg_write_out (reg_write_out),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_trap (misalign_trap),
`endif
        .wb_mux_out    (wb_mux_out)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [4:0]  rda;
        logic        rw;
        logic [1:0]  wbm;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_addr;
        logic [31:0] exp_ld;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic rd_, input logic wr_, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rda,
                           input logic rw, input logic [1:0] wm);
        in_valid     = 1'b1;
        mem_read     = rd_;
        mem_write    = wr_;
        mem_size     = sz;
        mem_unsigned = uns;
        alu_out      = a;
        store_data   = sd;
        rd_addr      = rda;
        reg_write    = rw;
        wb_mux       = wm;
    endtask

    initial begin
        //            rd    wr    sz     uns   addr          sd            rdata         rda    rw    wbm    be       wdata         daddr         load
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_1234, 32'h0,        32'h0,        5'd5,  1'b1, 2'b00, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'hFFFF_0000, 32'h0,        32'h0,        5'd31, 1'b0, 2'b10, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0,       5'd0,  1'b0, 2'b00, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0100, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'hFFFF_BEEF, 32'h0,       5'd0,  1'b0, 2'b00, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0204, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h1234_5678, 32'h0,       5'd0,  1'b0, 2'b00, 4'b1111, 32'h1234_5678, 32'h0000_0300, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0401, 32'h0,        32'h1122_8033, 5'd6,  1'b1, 2'b01, 4'b0010, 32'h0,        32'h0000_0400, 32'hFFFF_FF80};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0401, 32'h0,        32'h1122_8033, 5'd6,  1'b1, 2'b01, 4'b0010, 32'h0,        32'h0000_0400, 32'h0000_0080};
        vecs[7]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,        32'h8001_0000, 5'd8,  1'b1, 2'b01, 4'b1100, 32'h0,        32'h0000_0200, 32'hFFFF_8001};
        vecs[8]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0,        32'h8001_0000, 5'd8,  1'b1, 2'b01, 4'b1100, 32'h0,        32'h0000_0200, 32'h0000_8001};
        vecs[9]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0,        32'hDEAD_BEEF, 5'd9,  1'b1, 2'b01, 4'b1111, 32'h0,        32'h0000_0500, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0600, 32'hCAFE_F00D, 32'h0,       5'd0,  1'b0, 2'b00, 4'b1111, 32'hCAFE_F00D, 32'h0000_0600, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0403, 32'h0,        32'h7F00_0000, 5'd10, 1'b1, 2'b01, 4'b1000, 32'h0,        32'h0000_0400, 32'h0000_007F};

        rst_n = 1'b0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        present(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_be", dmem_be, 0);
        check("rst_load_data", load_data_wb, 0);
        check("rst_reg_write_out", reg_write_out, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            present(v.rd, v.wr, v.size, v.uns, v.addr, v.sd, v.rda, v.rw, v.wbm);
            step();
            in_valid = 1'b0;
            if (!(v.rd || v.wr)) begin
                check($sformatf("v%0d_out_valid", i), out_valid, 1);
                check($sformatf("v%0d_alu_out_wb", i), alu_out_wb, v.addr);
                check($sformatf("v%0d_rd_addr_out", i), rd_addr_out, v.rda);
                check($sformatf("v%0d_reg_write_out", i), reg_write_out, v.rw);
                check($sformatf("v%0d_wb_mux_out", i), wb_mux_out, v.wbm);
                step();
                check($sformatf("v%0d_idle_out_valid", i), out_valid, 0);
                check($sformatf("v%0d_idle_reg_write_out", i), reg_write_out, 0);
                check($sformatf("v%0d_hold_alu_out_wb", i), alu_out_wb, v.addr);
            end else begin
                check($sformatf("v%0d_req_out_valid", i), out_valid, 0);
                check($sformatf("v%0d_req_in_ready", i), in_ready, 0);
                check($sformatf("v%0d_dmem_req", i), dmem_req, 1);
                check($sformatf("v%0d_dmem_we", i), dmem_we, v.wr);
                check($sformatf("v%0d_dmem_addr", i), dmem_addr, v.exp_addr);
                check($sformatf("v%0d_dmem_be", i), dmem_be, v.exp_be);
                if (v.wr) check($sformatf("v%0d_dmem_wdata", i), dmem_wdata, v.exp_wd);
                dmem_ack = 1'b1; dmem_rdata = v.rdata;
                step();
                dmem_ack = 1'b0;
                check($sformatf("v%0d_ack_dmem_req", i), dmem_req, 0);
                check($sformatf("v%0d_ack_out_valid", i), out_valid, 1);
                check($sformatf("v%0d_ack_in_ready", i), in_ready, 1);
                check($sformatf("v%0d_ack_reg_write_out", i), reg_write_out, v.rw);
                if (v.rd) check($sformatf("v%0d_load_data_wb", i), load_data_wb, v.exp_ld);
                step();
                check($sformatf("v%0d_after_out_valid", i), out_valid, 0);
            end
        end

        // Signed half load held for three cycles before ack.
        present(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 5'd7, 1'b1, 2'b01);
        step();
        in_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            check($sformatf("wait%0d_dmem_req", w), dmem_req, 1);
            check($sformatf("wait%0d_in_ready", w), in_ready, 0);
            check($sformatf("wait%0d_out_valid", w), out_valid, 0);
            check($sformatf("wait%0d_dmem_addr", w), dmem_addr, 32'h0000_0200);
            step();
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
        step();
        dmem_ack = 1'b0;
        check("wait_load_data_wb", load_data_wb, 32'hFFFF_8001);
        check("wait_out_valid", out_valid, 1);
        check("wait_rd_addr_out", rd_addr_out, 7);
        check("wait_reg_write_out", reg_write_out, 1);
        step();

        // Flush during WAIT: request held, result discarded, next instruction accepted after ack.
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 5'd3, 1'b1, 2'b01);
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_dmem_req_held", dmem_req, 1);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        step();
        dmem_ack = 1'b0;
        check("flush_ack_out_valid", out_valid, 0);
        check("flush_ack_reg_write_out", reg_write_out, 0);
        check("flush_ack_dmem_req", dmem_req, 0);
        check("flush_ack_in_ready", in_ready, 1);
        present(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 5'd4, 1'b1, 2'b00);
        step();
        in_valid = 1'b0;
        check("post_flush_out_valid", out_valid, 1);
        check("post_flush_alu_out_wb", alu_out_wb, 32'h0000_0055);
        step();

        // Ack and flush in the same cycle.
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0700, 32'h0, 5'd2, 1'b1, 2'b01);
        step();
        in_valid = 1'b0;
        dmem_ack = 1'b1; flush = 1'b1; dmem_rdata = 32'h3333_4444;
        step();
        dmem_ack = 1'b0; flush = 1'b0;
        check("ackflush_out_valid", out_valid, 0);
        check("ackflush_dmem_req", dmem_req, 0);
        check("ackflush_in_ready", in_ready, 1);

        // Flush in IDLE rejects the presented instruction.
        present(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0077, 32'h0, 5'd1, 1'b1, 2'b00);
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_out_valid", out_valid, 0);
        check("idle_flush_reg_write_out", reg_write_out, 0);

        // Stray ack in IDLE.
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("stray_ack_out_valid", out_valid, 0);
        check("stray_ack_dmem_req", dmem_req, 0);
        check("stray_ack_in_ready", in_ready, 1);

        // Asynchronous reset while waiting for ack.
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0800, 32'h0, 5'd12, 1'b1, 2'b01);
        step();
        in_valid = 1'b0;
        check("prereset_dmem_req", dmem_req, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_dmem_req", dmem_req, 0);
        check("async_rst_out_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_dmem_req", dmem_req, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd13, 1'b1, 2'b01);
        step();
        in_valid = 1'b0;
        check("trap_dmem_req", dmem_req, 0);
        check("trap_out_valid", out_valid, 1);
        check("trap_reg_write_out", reg_write_out, 0);
        check("trap_flag", misalign_trap, 1);
        check("trap_in_ready", in_ready, 1);
        step();
        check("trap_clear", misalign_trap, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
